quad_step_decoder: RTL and testbench
====================================

QUAD_STEP_DECODER -- requirements
Module: quad_step_decoder

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive stable cycles required before an input change is accepted (range 1..255).
REQ-002 Port: clkpulse  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: a_in  input  1  raw quadrature channel A, asynchronous to clkpulse.
REQ-005 Port: b_in  input  1  raw quadrature channel B, asynchronous to clkpulse.
REQ-006 Port: clear  input  1  synchronous clear of pos and err.
REQ-007 Port: step  output  1  one-cycle pulse per accepted single-bit quadrature transition; feeds an up/down counter's count pulse.
REQ-008 Port: dir  output  1  direction of the most recent step, 1 = up (A leads B), 0 = down; feeds the counter's up/down select.
REQ-009 Port: pos  output  4  local position count, modulo 16.
REQ-010 Port: err  output  1  sticky illegal-transition flag.

Function
REQ-011 Synchronizer: each of a_in and b_in SHALL pass through a 2-flop synchronizer; the second stage is the synchronized value.
REQ-012 Debounce: each channel SHALL have an independent stable register and a cycle counter.
  - Counter resets to 0 on any edge where synchronized value equals stable value.
  - Counter increments on each edge where they differ.
  - Stable value takes the synchronized value on the edge where the counter would reach DEBOUNCE_CYCLES; counter returns to 0.
REQ-013 The decoder SHALL compare the current debounced pair {A,B} against the previous pair, registered one edge after the debounced update.
REQ-014 Forward (up) sequence: 00->10->11->01->00. Reverse (down) sequence: 00->01->11->10->00.
REQ-015 Forward transition: step=1 for exactly one cycle, dir=1, pos=pos+1 (15 wraps to 0).
REQ-016 Reverse transition: step=1 for exactly one cycle, dir=0, pos=pos-1 (0 wraps to 15).
REQ-017 Double-bit change (00<->11, 10<->01): step stays 0, dir and pos unchanged, err set to 1 and held until clear or rst.
REQ-018 No change in the debounced pair: step=0, dir holds its last value.
REQ-019 Latency: step SHALL assert on edge DEBOUNCE_CYCLES+2 after the edge that first samples a new stable raw value into the synchronizer (edge 6 for default 4).
REQ-020 Pulse stream: back-to-back accepted transitions SHALL produce separate one-cycle step pulses with no merging; the minimum spacing is set by debounce.
REQ-021 Clear:
  - clear=1 sets pos=0 and err=0 on the next edge.
  - If a step occurs on that same edge, step and dir still update but pos becomes 0.
  - clear has priority over pos arithmetic and over err set.
REQ-022 Arming: the first debounced pair update after reset SHALL only load the previous-pair register. It produces no step, no err and no pos change. An armed flag is set by that update.
REQ-023 Glitch rejection: an input pulse shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no step and no err.

Reset
REQ-024 On rst=1, immediately and independent of clkpulse:
  - Synchronizer flops, stable registers, debounce counters, previous pair and armed flag are cleared to 0.
  - step=0, dir=0, pos=0, err=0.
REQ-025 If rst asserts mid-debounce or mid-pulse, the pending change and any step SHALL be discarded.
REQ-026 After rst deasserts, the block SHALL operate normally from the first rising edge. The arming rule in REQ-022 applies.

Verification
REQ-027 Forward sweep, D=4, arming done: raw {A,B} 00->10->11->01->00, each held 10 cycles -> four step pulses, dir=1, pos 0->4, err=0; step on edge 6 after each change.
REQ-028 Reverse from pos=0: raw {A,B} 00->01 held 10 cycles -> one step, dir=0, pos=15 (wrap).
REQ-029 Glitch: A high for 3 cycles, then low -> step never asserts, pos and err unchanged.
REQ-030 Illegal transition: raw 00->11 simultaneously, held 10 cycles -> err=1, step=0, pos unchanged; then clear=1 for one cycle -> err=0, pos=0.
REQ-031 Reset mid-operation: rst pulsed 2 cycles after an A edge, during debounce -> all outputs 0 and no step afterward. Then raw held at 10 -> arming only, no step; then 10->11 -> step, dir=1, pos=1.
REQ-032 Clear-with-step: clear=1 on the same edge a forward step fires, with pos=7 -> step=1, dir=1, pos=0.

Source files
------------

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronises and debounces channels A/B, then turns
// each accepted single-bit transition into a step/dir pulse and a mod-16 position.
module quad_step_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clkpulse,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       clear,
  output logic       step,
  output logic       dir,
  output logic [3:0] pos,
  output logic       err
);

  localparam logic [8:0] LIMIT = 9'(DEBOUNCE_CYCLES);

  // Pair bit 1 is channel A, bit 0 is channel B throughout.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      stable;
  logic [1:0]      stable_next;
  logic [1:0]      accept;
  logic [1:0][7:0] cnt;
  logic            armed;
  logic            changed;
  logic            fwd;
  logic            rev;
  logic            dbl;

  always_ff @(posedge clkpulse or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {a_in, b_in};
      sync2 <= sync1;
    end
  end

  always_comb begin
    accept      = '0;
    stable_next = stable;
    for (int unsigned i = 0; i < 2; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (({1'b0, cnt[i]} + 9'd1) == LIMIT);
      if (accept[i]) stable_next[i] = sync2[i];
    end
  end

  always_ff @(posedge clkpulse or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i]    <= '0;
          stable[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // The stable register doubles as the previous pair: the decoder looks at the
  // pair about to be accepted, so step lands on the same edge as the update.
  always_comb begin
    changed = (stable_next != stable);
    fwd     = 1'b0;
    rev     = 1'b0;
    case ({stable, stable_next})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev = 1'b1;
      default: ;
    endcase
    dbl = changed && ((stable ^ stable_next) == 2'b11);
  end

  always_ff @(posedge clkpulse or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
      step  <= 1'b0;
      dir   <= 1'b0;
      pos   <= '0;
      err   <= 1'b0;
    end else begin
      step <= 1'b0;
      if (changed) begin
        if (!armed) begin
          armed <= 1'b1;
        end else if (fwd) begin
          step <= 1'b1;
          dir  <= 1'b1;
          pos  <= pos + 4'd1;
        end else if (rev) begin
          step <= 1'b1;
          dir  <= 1'b0;
          pos  <= pos - 4'd1;
        end else if (dbl) begin
          err <= 1'b1;
        end
      end
      // Clear wins over the arithmetic and the error set above; step/dir still update.
      if (clear) begin
        pos <= '0;
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus a random walk, all
// checked against a sample-history/phase-arithmetic reference model.
module tb_quad_step_decoder;

  localparam int unsigned D = 4;

  logic       clkpulse = 1'b0;
  logic       rst;
  logic       a_in;
  logic       b_in;
  logic       clear;
  logic       step;
  logic       dir;
  logic [3:0] pos;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0] hist [D+2];
  logic [1:0] m_stable;
  bit         m_armed;
  logic       m_step;
  logic       m_dir;
  logic [3:0] m_pos;
  logic       m_err;

  quad_step_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clkpulse(clkpulse),
    .rst     (rst),
    .a_in    (a_in),
    .b_in    (b_in),
    .clear   (clear),
    .step    (step),
    .dir     (dir),
    .pos     (pos),
    .err     (err)
  );

  initial forever #5 clkpulse = ~clkpulse;

  function automatic int phase(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(D) + 2; i++) hist[i] = 2'b00;
    m_stable = 2'b00;
    m_armed  = 0;
    m_step   = 1'b0;
    m_dir    = 1'b0;
    m_pos    = 4'd0;
    m_err    = 1'b0;
  endtask

  // A channel is accepted once the raw samples taken 2..D+1 edges ago all
  // disagree with its current stable value.
  task automatic model_edge();
    logic [1:0] nxt;
    bit         all;
    int         d;
    for (int i = int'(D) + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {a_in, b_in};
    nxt = m_stable;
    for (int ch = 0; ch < 2; ch++) begin
      all = 1;
      for (int k = 2; k <= int'(D) + 1; k++)
        if (hist[k][ch] == m_stable[ch]) all = 0;
      if (all) nxt[ch] = ~m_stable[ch];
    end
    m_step = 1'b0;
    if (nxt != m_stable) begin
      if (!m_armed) begin
        m_armed = 1;
      end else begin
        d = (phase(nxt) - phase(m_stable) + 4) % 4;
        if (d == 1) begin
          m_step = 1'b1; m_dir = 1'b1; m_pos = m_pos + 4'd1;
        end else if (d == 3) begin
          m_step = 1'b1; m_dir = 1'b0; m_pos = m_pos - 4'd1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    m_stable = nxt;
    if (clear) begin
      m_pos = 4'd0;
      m_err = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clkpulse);
    if (rst) model_reset();
    else model_edge();
    #1;
    check("step", {3'b0, step}, {3'b0, m_step});
    check("dir",  {3'b0, dir},  {3'b0, m_dir});
    check("pos",  pos,          m_pos);
    check("err",  {3'b0, err},  {3'b0, m_err});
  endtask

  task automatic hold(input logic [1:0] p, input int n, input bit lat);
    {a_in, b_in} = p;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (lat) check("latency_step", {3'b0, step}, {3'b0, (k == int'(D) + 2)});
    end
  endtask

  logic [1:0] cur;
  logic [1:0] gray [4];
  int         ph;
  int         r;
  int         dur;

  initial begin
    gray[0] = 2'b00; gray[1] = 2'b10; gray[2] = 2'b11; gray[3] = 2'b01;
    rst = 1'b1; a_in = 1'b0; b_in = 1'b0; clear = 1'b0;
    model_reset();
    #2;
    check("reset_step", {3'b0, step}, 4'd0);
    check("reset_pos",  pos,          4'd0);
    check("reset_err",  {3'b0, err},  4'd0);
    tick();
    rst = 1'b0;

    // Arm with 10, return to 00 (reverse), clear back to zero
    hold(2'b10, 10, 0);
    check("arm_no_step_pos", pos, 4'd0);
    hold(2'b00, 10, 0);
    check("post_arm_rev_pos", pos, 4'd15);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_pos", pos, 4'd0);

    // Forward sweep with explicit latency checks
    hold(2'b10, 10, 1);
    hold(2'b11, 10, 1);
    hold(2'b01, 10, 1);
    hold(2'b00, 10, 1);
    check("fwd_pos", pos, 4'd4);
    check("fwd_dir", {3'b0, dir}, 4'd1);
    check("fwd_err", {3'b0, err}, 4'd0);

    // Reverse from zero wraps to 15
    clear = 1'b1; tick(); clear = 1'b0;
    hold(2'b01, 10, 0);
    check("rev_pos", pos, 4'd15);
    check("rev_dir", {3'b0, dir}, 4'd0);
    hold(2'b00, 10, 0);

    // Glitch on A of D-1 cycles
    hold(2'b10, int'(D) - 1, 0);
    hold(2'b00, 12, 0);
    check("glitch_pos", pos, 4'd0);
    check("glitch_err", {3'b0, err}, 4'd0);

    // Illegal double change, then clear
    hold(2'b11, 10, 0);
    check("illegal_err", {3'b0, err}, 4'd1);
    check("illegal_pos", pos, 4'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    check("illegal_clear_err", {3'b0, err}, 4'd0);
    hold(2'b01, 10, 0);
    hold(2'b00, 10, 0);

    // Reset two edges into a debounce of A
    hold(2'b10, 2, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_pos", pos, 4'd0);
    check("midrst_dir", {3'b0, dir}, 4'd0);
    tick(); tick();
    rst = 1'b0;
    hold(2'b10, 10, 0);
    check("rearm_pos", pos, 4'd0);
    hold(2'b11, 10, 0);
    check("rearm_step_pos", pos, 4'd1);
    check("rearm_dir", {3'b0, dir}, 4'd1);

    // Walk forward to pos=7, then clear on the edge the next step fires
    hold(2'b01, 10, 0); hold(2'b00, 10, 0); hold(2'b10, 10, 0);
    hold(2'b11, 10, 0); hold(2'b01, 10, 0); hold(2'b00, 10, 0);
    check("pre_clear_pos", pos, 4'd7);
    hold(2'b10, int'(D) + 1, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    check("cws_step", {3'b0, step}, 4'd1);
    check("cws_dir",  {3'b0, dir},  4'd1);
    check("cws_pos",  pos,          4'd0);
    hold(2'b10, 6, 0);

    // Random walk
    cur = 2'b10;
    for (int it = 0; it < 250; it++) begin
      r   = $urandom_range(0, 9);
      dur = $urandom_range(1, int'(D) + 4);
      ph  = phase(cur);
      if (r <= 3)      cur = gray[(ph + 1) % 4];
      else if (r <= 6) cur = gray[(ph + 3) % 4];
      else if (r == 7) cur = gray[(ph + 2) % 4];
      else if (r == 8) begin
        {a_in, b_in} = cur ^ 2'b10;
        for (int k = 0; k < $urandom_range(1, int'(D) - 1); k++) tick();
      end
      for (int k = 0; k < dur; k++) begin
        clear = ($urandom_range(0, 19) == 0);
        {a_in, b_in} = cur;
        tick();
      end
      clear = 1'b0;
    end
    hold(cur, 10, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
